// File: rtl/assoc_cache_if.sv
// rtl/assoc_cache_if.sv - block-transfer bus between the L1 cache and the memory/DMA arbiter
interface assoc_cache_if #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4
);
  logic                              MEMORY_readM;
  logic                              MEMORY_writeM;
  logic [WORD_SIZE-1:0]              MEMORY_address;
  logic [WORD_SIZE*BLOCK_WORDS-1:0]  MEMORY_wdata;
  logic [WORD_SIZE*BLOCK_WORDS-1:0]  MEMORY_rdata;
  logic                              MEMORY_ready;

  modport master (
    output MEMORY_readM, MEMORY_writeM, MEMORY_address, MEMORY_wdata,
    input  MEMORY_rdata, MEMORY_ready
  );

  modport slave (
    input  MEMORY_readM, MEMORY_writeM, MEMORY_address, MEMORY_wdata,
    output MEMORY_rdata, MEMORY_ready
  );
endinterface

// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - 2-way set-associative write-back L1 cache with true-LRU and flush
module assoc_cache #(
  parameter int WORD_SIZE   = 16,
  parameter int INDEX_BITS  = 2,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CPU_readM,
  input  logic                 CPU_writeM,
  input  logic [WORD_SIZE-1:0] CPU_address,
  input  logic [WORD_SIZE-1:0] CPU_wdata,
  output logic [WORD_SIZE-1:0] CPU_rdata,
  output logic                 CPU_ready,
  input  logic                 flush,
  output logic                 flush_done,
  assoc_cache_if.master        mem,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);
  localparam int SETS        = 1 << INDEX_BITS;
  localparam int BLOCK_WORDS = 1 << OFFSET_BITS;
  localparam int BLOCK_BITS  = WORD_SIZE * BLOCK_WORDS;

  typedef enum logic [1:0] {IDLE, WB, FILL, FLUSH} state_t;

  state_t                  state;
  logic [TAG_BITS-1:0]     tags  [SETS][2];
  logic [BLOCK_BITS-1:0]   data  [SETS][2];
  logic [1:0]              valid [SETS];
  logic [1:0]              dirty [SETS];
  logic [SETS-1:0]         lru;

  logic [TAG_BITS-1:0]     lat_tag;
  logic [INDEX_BITS-1:0]   lat_set;
  logic                    lat_way;
  logic                    from_flush;
  logic                    flush_pend;
  logic                    pend_miss;
  logic [INDEX_BITS:0]     fptr;

  logic                    mem_read;
  logic                    mem_write;
  logic [WORD_SIZE-1:0]    mem_addr;
  logic [BLOCK_BITS-1:0]   mem_wdata;

  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   req_set;
  logic [OFFSET_BITS-1:0]  req_off;
  logic                    req, hit0, hit1, hit, vic_way, vic_dirty;
  logic [BLOCK_BITS-1:0]   hit_block;
  logic [INDEX_BITS-1:0]   f_set;
  logic                    f_way, f_dirty;

  // Word 0 sits in the MSBs of a block
  function automatic int word_lsb(input logic [OFFSET_BITS-1:0] off);
    return (BLOCK_WORDS - 1 - int'(off)) * WORD_SIZE;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign mem.MEMORY_readM   = mem_read;
  assign mem.MEMORY_writeM  = mem_write;
  assign mem.MEMORY_address = mem_addr;
  assign mem.MEMORY_wdata   = mem_wdata;

  always_comb begin
    req_tag   = CPU_address[WORD_SIZE-1 -: TAG_BITS];
    req_set   = CPU_address[OFFSET_BITS +: INDEX_BITS];
    req_off   = CPU_address[OFFSET_BITS-1:0];
    req       = CPU_readM | CPU_writeM;
    hit0      = valid[req_set][0] && (tags[req_set][0] == req_tag);
    hit1      = valid[req_set][1] && (tags[req_set][1] == req_tag);
    hit       = hit0 | hit1;
    hit_block = hit1 ? data[req_set][1] : data[req_set][0];
    CPU_ready = (state == IDLE) && (hit || !req);
    CPU_rdata = '0;
    if (state == IDLE && hit && CPU_readM)
      CPU_rdata = hit_block[word_lsb(req_off) +: WORD_SIZE];
    if (!valid[req_set][0])      vic_way = 1'b0;
    else if (!valid[req_set][1]) vic_way = 1'b1;
    else                         vic_way = lru[req_set];
    vic_dirty = valid[req_set][vic_way] && dirty[req_set][vic_way];
    f_set     = fptr[INDEX_BITS:1];
    f_way     = fptr[0];
    f_dirty   = valid[f_set][f_way] && dirty[f_set][f_way];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lru        <= '0;
      for (int i = 0; i < SETS; i++) begin
        valid[i] <= '0;
        dirty[i] <= '0;
      end
      lat_tag    <= '0;
      lat_set    <= '0;
      lat_way    <= 1'b0;
      from_flush <= 1'b0;
      flush_pend <= 1'b0;
      pend_miss  <= 1'b0;
      fptr       <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      flush_done <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (CPU_writeM) begin
              data[req_set][hit1][word_lsb(req_off) +: WORD_SIZE] <= CPU_wdata;
              dirty[req_set][hit1] <= 1'b1;
            end
            lru[req_set] <= ~hit1;
            // The completion of a request that already missed is not a hit
            if (pend_miss) pend_miss <= 1'b0;
            else           hit_count <= sat_inc(hit_count);
          end
          if (req && !hit) begin
            lat_tag    <= req_tag;
            lat_set    <= req_set;
            lat_way    <= vic_way;
            from_flush <= 1'b0;
            pend_miss  <= 1'b1;
            miss_count <= sat_inc(miss_count);
            if (flush) flush_pend <= 1'b1;
            if (vic_dirty) begin
              mem_write <= 1'b1;
              mem_addr  <= {tags[req_set][vic_way], req_set, {OFFSET_BITS{1'b0}}};
              mem_wdata <= data[req_set][vic_way];
              state     <= WB;
            end else begin
              mem_read  <= 1'b1;
              mem_addr  <= {req_tag, req_set, {OFFSET_BITS{1'b0}}};
              state     <= FILL;
            end
          end else if (flush || flush_pend) begin
            flush_pend <= 1'b0;
            fptr       <= '0;
            state      <= FLUSH;
          end
        end
        WB: begin
          if (flush && !from_flush) flush_pend <= 1'b1;
          if (mem.MEMORY_ready) begin
            mem_write <= 1'b0;
            dirty[lat_set][lat_way] <= 1'b0;
            if (from_flush) begin
              if (&fptr) begin
                state      <= IDLE;
                flush_done <= 1'b1;
              end else begin
                fptr  <= fptr + 1'b1;
                state <= FLUSH;
              end
            end else begin
              mem_read <= 1'b1;
              mem_addr <= {lat_tag, lat_set, {OFFSET_BITS{1'b0}}};
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (mem.MEMORY_ready) begin
            mem_read                <= 1'b0;
            data[lat_set][lat_way]  <= mem.MEMORY_rdata;
            tags[lat_set][lat_way]  <= lat_tag;
            valid[lat_set][lat_way] <= 1'b1;
            dirty[lat_set][lat_way] <= 1'b0;
            state                   <= IDLE;
          end
        end
        FLUSH: begin
          // Dirty lines borrow the WB handshake and come back here to advance
          if (f_dirty) begin
            lat_set    <= f_set;
            lat_way    <= f_way;
            from_flush <= 1'b1;
            mem_write  <= 1'b1;
            mem_addr   <= {tags[f_set][f_way], f_set, {OFFSET_BITS{1'b0}}};
            mem_wdata  <= data[f_set][f_way];
            state      <= WB;
          end else if (&fptr) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end else begin
            fptr <= fptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_cache.sv
// tb/tb_assoc_cache.sv - scoreboard bench for assoc_cache against a latency-3 block memory
module tb_assoc_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CPU_readM = 1'b0, CPU_writeM = 1'b0, flush = 1'b0;
  logic [15:0] CPU_address = '0, CPU_wdata = '0;
  logic [15:0] CPU_rdata, hit_count, miss_count;
  logic        CPU_ready, flush_done;
  logic        mem_ready = 1'b0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t         ev_q[$];
  logic [15:0] exp_q[$];
  logic [63:0] mem_arr [0:16383];
  logic [15:0] ref_mem [0:65535];
  int          n_checks = 0, n_err = 0;
  int          cyc, rc, m_cnt;
  bit          seen;

  always #5 clk = ~clk;

  assoc_cache_if #(.WORD_SIZE(16), .BLOCK_WORDS(4)) mif ();

  assign mif.MEMORY_ready = mem_ready;
  assign mif.MEMORY_rdata = mem_arr[mif.MEMORY_address[15:2]];

  assoc_cache #(.WORD_SIZE(16), .INDEX_BITS(2), .OFFSET_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .CPU_readM(CPU_readM), .CPU_writeM(CPU_writeM),
    .CPU_address(CPU_address), .CPU_wdata(CPU_wdata),
    .CPU_rdata(CPU_rdata), .CPU_ready(CPU_ready),
    .flush(flush), .flush_done(flush_done),
    .mem(mif),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Memory answers on the third cycle a strobe is seen, committing writes then
  initial begin
    int lat = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (reset) lat = 0;
      else if (mif.MEMORY_readM || mif.MEMORY_writeM) begin
        lat++;
        if (lat == 3) begin
          lat = 0;
          mem_ready = 1'b1;
          if (mif.MEMORY_writeM) begin
            mem_arr[mif.MEMORY_address[15:2]] = mif.MEMORY_wdata;
            ev_q.push_back('{1'b1, mif.MEMORY_address, mif.MEMORY_wdata});
          end else begin
            ev_q.push_back('{1'b0, mif.MEMORY_address, mif.MEMORY_rdata});
          end
        end
      end else lat = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_blk(input logic [15:0] a);
    return {ref_mem[a], ref_mem[a | 16'd1], ref_mem[a | 16'd2], ref_mem[a | 16'd3]};
  endfunction

  // Dirty lines die with a reset, so the visible memory is what memory holds
  task automatic sync_ref();
    for (int b = 0; b < 16384; b++)
      for (int i = 0; i < 4; i++)
        ref_mem[b*4 + i] = mem_arr[b][(3-i)*16 +: 16];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sync_ref();
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic cpu_op(input bit wr, input logic [15:0] a, input logic [15:0] d, output int n);
    n = 0;
    if (wr) ref_mem[a] = d;
    else    exp_q.push_back(ref_mem[a]);
    CPU_readM = !wr; CPU_writeM = wr; CPU_address = a; CPU_wdata = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n++;
      if (CPU_ready) break;
    end
    if (!CPU_ready) begin
      chk("op_timeout", 0, 1);
      if (!wr) void'(exp_q.pop_front());
    end else if (!wr) begin
      chk("rdata", CPU_rdata, exp_q.pop_front());
    end
    @(posedge clk);
    #1 CPU_readM = 1'b0; CPU_writeM = 1'b0;
  endtask

  task automatic do_flush(output bit done, output int rdy);
    done = 1'b0; rdy = 0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (flush_done) begin done = 1'b1; break; end
      if (CPU_ready) rdy++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int b = 0; b < 16384; b++)
      for (int i = 0; i < 4; i++)
        mem_arr[b][(3-i)*16 +: 16] = 16'((b*4 + i) ^ 16'h5A5A);
    mem_arr[4] = {16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    repeat (2) @(posedge clk);
    do_reset();

    @(negedge clk);
    chk("rst_ready", CPU_ready, 1);
    chk("rst_rdata", CPU_rdata, 0);
    chk("rst_strobes", {mif.MEMORY_readM, mif.MEMORY_writeM, flush_done}, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    @(posedge clk); #1;

    // Cold read then a zero-wait hit in the same block
    cpu_op(0, 16'h0012, 0, cyc);
    chk("cold_lat", cyc, 5);
    chk("cold_fills", ev_q.size(), 1);
    if (ev_q.size() > 0) chk("cold_addr", {ev_q[0].wr, ev_q[0].addr}, {1'b0, 16'h0010});
    chk("cold_miss", miss_count, 1);
    chk("cold_hit", hit_count, 0);
    cpu_op(0, 16'h0013, 0, cyc);
    chk("warm_lat", cyc, 1);
    chk("warm_hit", hit_count, 1);

    // LRU: 0x0010 is least recent when 0x0020 arrives
    do_reset();
    cpu_op(0, 16'h0000, 0, cyc);
    cpu_op(0, 16'h0010, 0, cyc);
    cpu_op(0, 16'h0000, 0, cyc);
    chk("lru_hit_lat", cyc, 1);
    cpu_op(0, 16'h0020, 0, cyc);
    chk("lru_miss_cnt", miss_count, 3);
    cpu_op(0, 16'h0000, 0, cyc);
    chk("lru_keep_lat", cyc, 1);
    cpu_op(0, 16'h0010, 0, cyc);
    chk("lru_evict_lat", cyc, 5);
    chk("lru_miss_cnt2", miss_count, 4);

    // Dirty eviction writes back before filling
    do_reset();
    cpu_op(1, 16'h0001, 16'h1234, cyc);
    chk("wr_alloc_lat", cyc, 5);
    cpu_op(0, 16'h0010, 0, cyc);
    ev_q.delete();
    cpu_op(0, 16'h0020, 0, cyc);
    chk("dirty_lat", cyc, 8);
    chk("dirty_events", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      chk("dirty_wb_addr", {ev_q[0].wr, ev_q[0].addr}, {1'b1, 16'h0000});
      chk("dirty_wb_data", ev_q[0].data, ref_blk(16'h0000));
      chk("dirty_fill_addr", {ev_q[1].wr, ev_q[1].addr}, {1'b0, 16'h0020});
    end
    cpu_op(0, 16'h0001, 0, cyc);

    // Flush writes back set 0 then set 3, leaves lines valid
    do_reset();
    cpu_op(1, 16'h0002, 16'hBEEF, cyc);
    cpu_op(1, 16'h000E, 16'hCAFE, cyc);
    cpu_op(0, 16'h0005, 0, cyc);
    ev_q.delete();
    do_flush(seen, rc);
    chk("flush_done", seen, 1);
    chk("flush_ready_low", rc, 0);
    chk("flush_wbs", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      chk("flush_wb0", {ev_q[0].wr, ev_q[0].addr}, {1'b1, 16'h0000});
      chk("flush_wb0_data", ev_q[0].data, ref_blk(16'h0000));
      chk("flush_wb1", {ev_q[1].wr, ev_q[1].addr}, {1'b1, 16'h000C});
      chk("flush_wb1_data", ev_q[1].data, ref_blk(16'h000C));
    end
    ev_q.delete();
    do_flush(seen, rc);
    chk("reflush_done", seen, 1);
    chk("reflush_wbs", ev_q.size(), 0);
    cpu_op(0, 16'h0002, 0, cyc);
    chk("post_flush_hit", cyc, 1);

    // Reset while a fill is outstanding
    do_reset();
    CPU_readM = 1'b1; CPU_address = 16'h0040;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mif.MEMORY_readM) break;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_fill_strobe", mif.MEMORY_readM, 0);
    chk("rst_fill_counts", {hit_count, miss_count}, 0);
    @(posedge clk);
    #1 reset = 1'b0; CPU_readM = 1'b0;
    sync_ref();
    ev_q.delete();
    cpu_op(0, 16'h0040, 0, cyc);
    chk("rst_refill_lat", cyc, 5);
    chk("rst_refill_miss", miss_count, 1);

    // Saturating hit counter
    do_reset();
    cpu_op(0, 16'h0000, 0, cyc);
    CPU_readM = 1'b1; CPU_address = 16'h0000;
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", hit_count, 16'hFFFE);
    repeat (6) @(posedge clk);
    #1 chk("sat_ffff", hit_count, 16'hFFFF);
    chk("sat_rdata", CPU_rdata, ref_mem[0]);
    chk("sat_miss", miss_count, 1);
    CPU_readM = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised 2-way set-associative L1 cache with write-back and write-allocate policy, sitting between the CPU memory port and the memory/DMA arbiter in the cached-CPU build.
- Generalises the direct-mapped cache with configurable set count and block size, a true-LRU victim policy per set, an explicit memory handshake, a software-triggered flush of all dirty lines, and saturating hit/miss counters.

Parameters:
- WORD_SIZE, 16, CPU word width and address width.
- INDEX_BITS, 2, set-index bits; sets = 2^INDEX_BITS.
- OFFSET_BITS, 2, word-offset bits; BLOCK_WORDS = 2^OFFSET_BITS.
- TAG_BITS, WORD_SIZE-INDEX_BITS-OFFSET_BITS, tag width (derived).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- CPU_readM  in  1  read request; held stable until CPU_ready=1.
- CPU_writeM  in  1  write request; held stable until CPU_ready=1.
- CPU_address  in  WORD_SIZE  word address {tag, index, offset}.
- CPU_wdata  in  WORD_SIZE  write data.
- CPU_rdata  out  WORD_SIZE  read data; valid when CPU_ready=1 and CPU_readM=1.
- CPU_ready  out  1  request complete this cycle, or cache idle with no request.
- flush  in  1  one-cycle pulse that starts a write-back of all dirty lines.
- flush_done  out  1  one-cycle pulse when the flush finishes.
- MEMORY_readM  out  1  block read strobe; held until MEMORY_ready.
- MEMORY_writeM  out  1  block write strobe; held until MEMORY_ready.
- MEMORY_address  out  WORD_SIZE  block-aligned address (offset bits = 0).
- MEMORY_wdata  out  WORD_SIZE*BLOCK_WORDS  write-back block; word 0 in the MSBs.
- MEMORY_rdata  in  WORD_SIZE*BLOCK_WORDS  fill block, same packing; valid with MEMORY_ready.
- MEMORY_ready  in  1  one-cycle pulse marking completion of the current strobe.
- hit_count  out  16  saturating count of requests served without a miss.
- miss_count  out  16  saturating count of misses.

Behaviour:
- Per set, per way: valid, dirty, tag and data; plus one lru bit per set naming the least-recently-used way.
- Reset: all valid, dirty and lru bits cleared; state IDLE; MEMORY strobes 0; flush_done 0; counters 0; CPU_rdata 0.
  - Reset mid-transfer abandons the transfer; strobes drop on the cycle after reset is sampled.
  - Dirty data held at reset is lost.
- States: IDLE, WB, FILL, FLUSH.
- Lookup (IDLE, combinational):
  - hit = any way with valid && tag match.
  - CPU_ready = 1 in IDLE when hit or no request; 0 in every other state.
  - CPU_rdata = the hit way's word at offset; 0 when there is no read hit.
- Read hit: zero-wait; lru[set] set to the other way at the posedge.
- Write hit: the word is written at the posedge, dirty set and lru updated; there is no memory traffic.
- Miss in IDLE: at the posedge, latch address, set index and victim way, then increment miss_count.
  - Victim choice: way0 if invalid, else way1 if invalid, else lru[set].
  - Next state is WB if the victim is valid and dirty, otherwise FILL.
- WB: MEMORY_writeM=1, MEMORY_address={victim tag, set, 0}, MEMORY_wdata=victim block. On MEMORY_ready: clear the victim's dirty bit, go to FILL.
- FILL: MEMORY_readM=1, MEMORY_address={latched tag, set, 0}. On MEMORY_ready:
  - load the block and tag into the victim way;
  - valid=1, dirty=0;
  - go to IDLE.
- After a fill, the held request hits on the next cycle and completes as a normal read or write hit; that hit is not counted in hit_count.
- Minimum miss latency:
  - clean miss = 1 + L(fill) + 1 cycles;
  - dirty miss adds L(wb), where L is cycles to MEMORY_ready.
- Both CPU strobes high: treated as a write; CPU_rdata is still driven.
- MEMORY_ready outside WB, FILL or a FLUSH write-back is ignored.
- Flush:
  - Accepted only in IDLE when the request is idle or hits that cycle; a pending miss is served first and flush is latched until the return to IDLE.
  - FLUSH walks set 0..sets-1 and way 0..1. Each valid+dirty line is written back through the WB handshake and its dirty bit cleared; valid and lru are unchanged.
  - Clean lines take 1 cycle each.
  - flush_done pulses the cycle FLUSH returns to IDLE. flush asserted during FLUSH is ignored.
- hit_count increments on each cycle where CPU_ready=1 with a request, only if that request caused no miss. Both counters stick at 16'hFFFF.

Test Plan:
- Configuration for all scenarios: INDEX_BITS=2, OFFSET_BITS=2, memory latency 3.
- Cold read: read 0x0012 after reset, memory block {0xA0,0xA1,0xA2,0xA3}.
  - Response: one FILL at MEMORY_address 0x0010, CPU_ready on the 5th cycle, CPU_rdata 0xA2, miss_count 1, hit_count 0.
  - Then read 0x0013: zero-wait, returns 0xA3, hit_count 1.
- Two-way conflict, then LRU:
  - Stimulus: fill 0x0000 and 0x0010, read 0x0000, then read 0x0020.
  - Response: way holding 0x0010 evicted; a re-read of 0x0000 hits, a re-read of 0x0010 misses.
- Dirty eviction:
  - Stimulus: write 0x1234 to 0x0001 (hit after fill), then miss 0x0010 and 0x0020 in set 0.
  - Response: the 0x0020 miss issues a WB to 0x0000 with word1=0x1234 before the FILL of 0x0020.
- Flush:
  - Stimulus: dirty lines in sets 0 and 3, pulse flush.
  - Response: exactly two write-backs (set 0, then set 3), flush_done pulse, CPU_ready=0 throughout; a repeat flush issues none.
- Reset mid-FILL: reset asserted during the FILL wait.
  - Response: MEMORY_readM=0 next cycle, the next read of the same address misses again, counters 0.
- Saturation:
  - Stimulus: preload hit_count near its limit via 65540 read hits to one line.
  - Response: hit_count holds 16'hFFFF.
